ascii2hex: RTL
==============

# ascii2hex

Receive-side counterpart of the hex-to-ASCII transmit formatter in the temperature-monitor datapath. Sits between the UART receiver and the command parser. With `a2h_en` high, each pair of ASCII hex-digit characters is packed into one binary byte. With `a2h_en` low, received bytes pass through unchanged. Includes nibble-pair state tracking, separator handling, an inter-character timeout and an error strobe.

## Interface

- `TIMEOUT`, default 100000: clock cycles the block waits for the low nibble after accepting a high nibble (4 ms at 25 MHz).
- `CNT_W`, default 17: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.
- `clk`  in  1  system clock; one clock domain only.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `a2h_en`  in  1  mode select, sampled only on cycles where `din_vld`=1. 1 = hex-pair packing, 0 = raw pass-through.
- `din`  in  8  received character from the UART receiver.
- `din_vld`  in  1  single-cycle strobe; `din` is valid on this cycle.
- `dout`  out  8  output byte; holds its last value between strobes.
- `dout_vld`  out  1  single-cycle strobe; `dout` is valid on this cycle.
- `err`  out  1  single-cycle strobe on a protocol error.

## Operation

- States:
  - IDLE: no nibble pending.
  - HOLD: high nibble latched in `hi_nib[3:0]`.
- Digit decode:
  - 0x30-0x39 → 0-9.
  - 0x41-0x46 → A-F.
  - 0x61-0x66 → a-f.
- Separators: 0x20 (space), 0x0D (CR), 0x0A (LF).
- Any other byte is invalid.
- `din_vld` with `a2h_en`=0, any state:
  - `dout`=`din`, `dout_vld` pulses.
  - If the state was HOLD, the pending nibble is discarded silently (no `err`) and the state goes to IDLE.
- `din_vld` with `a2h_en`=1, state IDLE:
  - Digit: latch `hi_nib`, clear the timeout counter, go to HOLD.
  - Separator: ignored, no strobe.
  - Invalid: `err` pulses, stay in IDLE.
- `din_vld` with `a2h_en`=1, state HOLD:
  - Digit: `dout`={`hi_nib`,digit}, `dout_vld` pulses, go to IDLE.
  - Separator or invalid: `err` pulses, `hi_nib` is discarded, go to IDLE.
- Timeout:
  - The counter increments each cycle in HOLD without `din_vld`.
  - When it reaches TIMEOUT-1: `err` pulses, go to IDLE.
- `dout_vld` and `err` are never asserted on the same cycle.
- No back-pressure: the downstream consumer must accept every `dout_vld` strobe.

## Timing

- Reset values: `dout`=0x00, `dout_vld`=0, `err`=0, state=IDLE, `hi_nib`=0, counter=0.
- All outputs are registered.
- `dout_vld` and `err` assert on the clock edge following the triggering `din_vld` cycle (latency 1).
- Timeout `err` asserts on the edge after the counter reaches TIMEOUT-1. This is exactly TIMEOUT cycles after HOLD was entered.
- `din_vld` on the same cycle the counter reaches TIMEOUT-1: `din_vld` wins. The character is processed as the low nibble and no timeout `err` is raised.
- Back-to-back `din_vld` on consecutive cycles must be handled. Each strobe is processed independently; a pair can complete in 2 cycles.
- Reset mid-operation (state HOLD): the pending nibble is lost and every output returns to its reset value asynchronously. No strobe is emitted after reset release until a new `din_vld` arrives.
- `a2h_en` changing between characters of a pair: the mode is taken from the second character's cycle (see the pass-through rule above).

## Configuration

- `A2H_TIMEOUT_EN` defined:
  - The timeout counter and its `err` path are compiled in.
  - `TIMEOUT` and `CNT_W` are used.
- `A2H_TIMEOUT_EN` undefined:
  - No counter is instantiated.
  - HOLD persists indefinitely until the next `din_vld` or reset.
  - `err` is raised only by separator or invalid characters.
  - `TIMEOUT` and `CNT_W` are unused.

## Test plan

- Pair packing, `a2h_en`=1: send 0x34 ('4') then 0x41 ('A') 5 cycles apart → `dout`=0x4A with a single `dout_vld` pulse, 1 cycle after the second strobe; `err` stays 0.
- Lower case and separators, `a2h_en`=1: send 0x20, 0x61 ('a'), 0x66 ('f'), 0x0D → one `dout`=0xAF; the separators alone raise no `err`. Then send 0x37 ('7') followed by 0x0A → `err` pulses once and there is no `dout_vld`.
- Raw mode, `a2h_en`=0: send 0x4A, then 0x47 → `dout`=0x4A, then `dout`=0x47, two `dout_vld` pulses, no `err`.
- Invalid character, `a2h_en`=1: send 0x47 ('G') → `err` pulses; a following pair 0x31, 0x32 → `dout`=0x12.
- Timeout, with `A2H_TIMEOUT_EN` defined and TIMEOUT=20:
  - Send 0x35, then nothing → `err` pulses exactly 20 cycles after HOLD entry.
  - Repeat, with 0x36 arriving on cycle 19 → `dout`=0x56 and no `err`.
  - Without the macro, the same idle gap → no `err`, and 0x36 arriving on cycle 50 → `dout`=0x56.
- Reset mid-pair: send 0x39, pulse `rst_n` low for 2 cycles, then send 0x41, 0x42 → `dout`=0xAB only. No strobe carries the pre-reset nibble 9.

Source files
------------

// File: rtl/ascii2hex.sv
// ascii2hex: packs pairs of ASCII hex digits into bytes, or passes raw bytes through
// Optional feature macro: A2H_TIMEOUT_EN (compiles in the low-nibble timeout).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   a2h_en            1 = hex-pair packing, 0 = raw pass-through (sampled with din_vld)
//   din, din_vld      received character and its single-cycle strobe
//   dout, dout_vld    output byte (held between strobes) and its strobe
//   err               single-cycle protocol/timeout error strobe
module ascii2hex #(
  parameter int TIMEOUT = 100000,
  parameter int CNT_W   = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a2h_en,
  input  logic [7:0] din,
  input  logic       din_vld,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       err
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nx;
  logic [3:0] hi_nib, hi_nib_nx, dig;
  logic [7:0] dout_nx, lc;
  logic vld_nx, err_nx, num, alpha, is_dig, is_sep, tmo;
  if (TIMEOUT >= (1 << CNT_W)) begin : g_bad_cnt_w
    $error("ascii2hex: CNT_W too narrow for TIMEOUT");
  end
  // Forcing bit 5 folds 'A'-'F' onto 'a'-'f'; no other byte lands in that range.
  assign lc     = din | 8'h20;
  assign num    = din >= 8'h30 && din <= 8'h39;
  assign alpha  = lc >= 8'h61 && lc <= 8'h66;
  assign is_dig = num || alpha;
  assign dig    = num ? din[3:0] : din[3:0] + 4'd9;
  assign is_sep = din == 8'h20 || din == 8'h0D || din == 8'h0A;
`ifdef A2H_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  // Counter only runs while waiting in HOLD; any strobe or IDLE clears it.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (state == HOLD && !din_vld) ? cnt + 1'b1 : '0;
  assign tmo = state == HOLD && !din_vld && cnt == CNT_W'(TIMEOUT - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_nx  = state;
    hi_nib_nx = hi_nib;
    dout_nx   = dout;
    vld_nx    = 1'b0;
    err_nx    = 1'b0;
    if (din_vld) begin
      if (!a2h_en) begin
        dout_nx  = din;
        vld_nx   = 1'b1;
        state_nx = IDLE;
      end else if (state == IDLE) begin
        hi_nib_nx = is_dig ? dig : hi_nib;
        state_nx  = is_dig ? HOLD : IDLE;
        err_nx    = !is_dig && !is_sep;
      end else begin
        dout_nx  = is_dig ? {hi_nib, dig} : dout;
        vld_nx   = is_dig;
        err_nx   = !is_dig;
        state_nx = IDLE;
      end
    end else if (tmo) begin
      err_nx   = 1'b1;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      hi_nib   <= 4'h0;
      dout     <= 8'h00;
      dout_vld <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      hi_nib   <= hi_nib_nx;
      dout     <= dout_nx;
      dout_vld <= vld_nx;
      err      <= err_nx;
    end
endmodule
